// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd on clk_i and recovers MSB-first left/right words
// using standard one-bit WS delay framing, with length-error accounting.
module i2s_rx #(
  parameter int AUDIO_DW  = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sck_i,
  input  logic                 ws_i,
  input  logic                 sd_i,
  input  logic                 en_i,
  input  logic                 err_clr_i,
  output logic [AUDIO_DW-1:0]  l_data_o,
  output logic [AUDIO_DW-1:0]  r_data_o,
  output logic                 l_valid_o,
  output logic                 r_valid_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 locked_o
);

  localparam int CNT_W = $clog2(AUDIO_DW + 2);

  typedef enum logic {ST_UNSYNC, ST_RUN} state_t;

  state_t              r_state;
  logic [2:0]          r_sck_sync;
  logic [1:0]          r_ws_sync;
  logic [1:0]          r_sd_sync;
  logic                r_ws_prev;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [AUDIO_DW-1:0] r_shreg;

  logic                w_sck_rise;
  logic                w_ws;
  logic                w_sd;
  logic                w_ws_edge;
  logic                w_len_ok;
  logic [AUDIO_DW-1:0] w_sh_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], sck_i};
      r_ws_sync  <= {r_ws_sync[0], ws_i};
      r_sd_sync  <= {r_sd_sync[0], sd_i};
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_ws       = r_ws_sync[1];
  assign w_sd       = r_sd_sync[1];
  assign w_ws_edge  = (w_ws != r_ws_prev);
  assign w_len_ok   = (r_bit_cnt == CNT_W'(AUDIO_DW - 1));

  // Bits beyond AUDIO_DW match no position and are dropped, keeping the MSBs.
  always_comb begin
    w_sh_next = r_shreg;
    for (int unsigned i = 0; i < AUDIO_DW; i++) begin
      if (r_bit_cnt == CNT_W'(AUDIO_DW - 1 - i)) w_sh_next[i] = w_sd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_UNSYNC;
      r_ws_prev <= 1'b0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      l_data_o  <= '0;
      r_data_o  <= '0;
      l_valid_o <= 1'b0;
      r_valid_o <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      locked_o  <= 1'b0;
    end else begin
      l_valid_o <= 1'b0;
      r_valid_o <= 1'b0;
      if (err_clr_i) begin
        err_o     <= 1'b0;
        err_cnt_o <= '0;
      end
      if (!en_i) begin
        r_state   <= ST_UNSYNC;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
        locked_o  <= 1'b0;
        if (w_sck_rise) r_ws_prev <= w_ws;
      end else if (w_sck_rise) begin
        r_ws_prev <= w_ws;
        if (r_state == ST_UNSYNC) begin
          if (w_ws_edge) begin
            r_state   <= ST_RUN;
            locked_o  <= 1'b1;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
          end
        end else if (w_ws_edge) begin
          // Current bit closes the word of the previous channel.
          if (r_ws_prev) begin
            r_data_o  <= w_sh_next;
            r_valid_o <= 1'b1;
          end else begin
            l_data_o  <= w_sh_next;
            l_valid_o <= 1'b1;
          end
          if (!w_len_ok && !err_clr_i) begin
            err_o <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
          end
          r_shreg   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shreg <= w_sh_next;
          if (r_bit_cnt != CNT_W'(AUDIO_DW + 1)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S bit streams and checks recovered words against a
// word-level model (bit queues per word) plus literal expectations.
module tb_i2s_rx;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst, sck, ws, sd, en, err_clr;
  logic [DW-1:0] l_data, r_data;
  logic l_valid, r_valid, err, locked;
  logic [CW-1:0] err_cnt;

  i2s_rx #(.AUDIO_DW(DW), .ERR_CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd), .en_i(en),
    .err_clr_i(err_clr), .l_data_o(l_data), .r_data_o(r_data),
    .l_valid_o(l_valid), .r_valid_o(r_valid), .err_o(err),
    .err_cnt_o(err_cnt), .locked_o(locked)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
    logic          err;
    logic [CW-1:0] cnt;
    int unsigned   due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  bit          m_bits[$];
  bit          m_prev, m_locked, m_en, m_clr, m_err;
  int unsigned m_cnt;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Word-level model: collects bits per word; a WS change closes the previous channel's word.
  function automatic void model_rise(bit w, bit d);
    logic [DW-1:0] dv;
    if (!m_en) begin
      m_prev = w;
      return;
    end
    if (!m_locked) begin
      if (w != m_prev) begin
        m_locked = 1'b1;
        m_bits.delete();
      end
      m_prev = w;
      return;
    end
    m_bits.push_back(d);
    if (w != m_prev) begin
      dv = '0;
      for (int i = 0; i < DW; i++) if (i < m_bits.size()) dv[DW-1-i] = m_bits[i];
      if (m_clr) begin
        m_cnt = 0;
        m_err = 1'b0;
      end else if (m_bits.size() != DW) begin
        m_err = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      q.push_back('{ch: m_prev, data: dv, err: m_err, cnt: CW'(m_cnt), due: cyc + 3});
      m_bits.delete();
    end
    m_prev = w;
  endfunction

  function automatic void model_reset();
    m_prev = 1'b0;
    m_locked = 1'b0;
    m_bits.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (l_valid || r_valid) begin
      check("valid_excl", 32'(l_valid & r_valid), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_valid", 32'({l_valid, r_valid}), 32'd0);
      end else begin
        e = q.pop_front();
        check("strobe_cycle", cyc, e.due);
        check("strobe_chan", 32'(r_valid), 32'(e.ch));
        check(e.ch ? "r_data" : "l_data", 32'(e.ch ? r_data : l_data), 32'(e.data));
        check("err_o", 32'(err), 32'(e.err));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("missing_valid", 32'({l_valid, r_valid}), e.ch ? 32'd1 : 32'd2);
    end
  end

  task automatic tick(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(bit w, bit d, int unsigned half);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    tick(half);
    sck = 1'b1;
    model_rise(w, d);
    tick(half);
  endtask

  task automatic send_word(bit ch, logic [15:0] val, int unsigned len, int unsigned half,
                           bit clr_last);
    for (int unsigned i = 0; i < len; i++) begin
      bit b;
      bit w;
      b = val[len-1-i];
      w = (i == len - 1) ? ~ch : ch;
      if (clr_last && i == len - 1) begin
        err_clr = 1'b1;
        m_clr   = 1'b1;
      end
      send_bit(w, b, half);
    end
    err_clr = 1'b0;
    m_clr   = 1'b0;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_l_data"}, 32'(l_data), 32'd0);
    check({tag, "_r_data"}, 32'(r_data), 32'd0);
    check({tag, "_valids"}, 32'({l_valid, r_valid}), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  logic [7:0] la, rb;

  initial begin
    rst = 1'b1; en = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; err_clr = 1'b0;
    m_en = 1'b1; m_clr = 1'b0;
    model_reset();
    tick(4);
    check_idle("reset");
    rst = 1'b0;
    tick(2);

    // Stream starts mid-left-word: lock on the first WS edge, partial word discarded.
    send_bit(1'b0, 1'b1, 4);
    send_bit(1'b0, 1'b0, 4);
    check("prelock_locked", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b1, 4);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_l_data", 32'(l_data), 32'd0);

    send_word(1'b1, 16'h00, 8, 4, 1'b0);
    send_word(1'b0, 16'hA5, 8, 4, 1'b0);
    send_word(1'b1, 16'h3C, 8, 4, 1'b0);
    tick(6);
    check("nom_l_data", 32'(l_data), 32'hA5);
    check("nom_r_data", 32'(r_data), 32'h3C);
    check("nom_err_cnt", 32'(err_cnt), 32'd0);

    send_word(1'b0, 16'h333, 10, 4, 1'b0);
    tick(6);
    check("long_l_data", 32'(l_data), 32'hCC);
    check("long_err", 32'(err), 32'd1);
    check("long_err_cnt", 32'(err_cnt), 32'd1);
    send_word(1'b1, 16'h2D, 6, 4, 1'b0);
    tick(6);
    check("short_r_data", 32'(r_data), 32'hB4);
    check("short_err_cnt", 32'(err_cnt), 32'd2);

    for (int unsigned i = 0; i < 300; i++) send_word(i[0], 16'(i & 32'h7F), 7, 2, 1'b0);
    tick(6);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_err", 32'(err), 32'd1);

    send_word(1'b0, 16'h11, 7, 4, 1'b1);
    tick(6);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    send_word(1'b1, 16'h5A, 8, 4, 1'b0);
    tick(6);
    check("post_clr_r_data", 32'(r_data), 32'h5A);
    check("post_clr_err_cnt", 32'(err_cnt), 32'd0);

    // Reset after 4 bits of a left word.
    send_bit(1'b0, 1'b1, 4);
    send_bit(1'b0, 1'b0, 4);
    send_bit(1'b0, 1'b1, 4);
    send_bit(1'b0, 1'b1, 4);
    sck = 1'b0;
    tick(2);
    rst = 1'b1;
    model_reset();
    tick(3);
    check_idle("midrst");
    rst = 1'b0;
    tick(2);
    for (int unsigned i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 4);
    check("rst_prelock", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b1, 4);
    check("rst_relock", 32'(locked), 32'd1);
    check("rst_l_data", 32'(l_data), 32'd0);
    send_word(1'b1, 16'h81, 8, 4, 1'b0);
    send_word(1'b0, 16'h7E, 8, 4, 1'b0);
    tick(6);
    check("resync_r_data", 32'(r_data), 32'h81);
    check("resync_l_data", 32'(l_data), 32'h7E);

    // Enable drop mid-right-word.
    for (int unsigned i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 4);
    en = 1'b0;
    m_en = 1'b0;
    m_locked = 1'b0;
    m_bits.delete();
    tick(2);
    check("en_low_locked", 32'(locked), 32'd0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 4);
    send_bit(1'b0, 1'b1, 4);
    en = 1'b1;
    m_en = 1'b1;
    send_word(1'b0, 16'hFF, 8, 4, 1'b0);
    check("en_relock", 32'(locked), 32'd1);
    check("en_l_hold", 32'(l_data), 32'h7E);
    send_word(1'b1, 16'h42, 8, 4, 1'b0);
    send_word(1'b0, 16'h24, 8, 4, 1'b0);
    tick(6);
    check("en_r_data", 32'(r_data), 32'h42);
    check("en_l_data", 32'(l_data), 32'h24);
    check("en_err_cnt", 32'(err_cnt), 32'd0);

    // Fast stream at sck = clk/4 with pseudo-random words.
    la = '0;
    rb = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      la = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 127));
      send_word(1'b1, 16'(rb), 8, 2, 1'b0);
      send_word(1'b0, 16'(la), 8, 2, 1'b0);
    end
    tick(6);
    check("fast_l_data", 32'(l_data), 32'(la));
    check("fast_r_data", 32'(r_data), 32'(rb));

    tick(10);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
